// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port synchronous data memory between the
// core load/store path and a host preload/readback port. One access per
// cycle, round-robin on ties, optional host lock for bursts, and read data
// routed back to the issuing requester one cycle after its grant.
//
// Handshake (both ports): a requester raises *_req with its command
// (we/addr/wdata) and holds all of it stable until it sees *_gnt high in the
// same cycle; the access is issued in exactly that cycle. Dropping *_req
// before a grant withdraws the request with no side effects.
module dmem_arbiter #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_gnt,
    output logic          core_rvalid,
    output logic [DW-1:0] core_rdata,

    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    input  logic          host_lock,
    output logic          host_gnt,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,

    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,

    output logic          busy
);

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_HOST = 1'b1
    } owner_e;

    owner_e        last_owner_q, last_owner_d;
    logic          locked_q, locked_d;
    logic          rd_pend_q, rd_pend_d;
    owner_e        rd_owner_q, rd_owner_d;
    logic [DW-1:0] core_rdata_q, core_rdata_d;
    logic [DW-1:0] host_rdata_q, host_rdata_d;

    logic          lock_active;
    logic          core_win;
    logic          host_win;

    // Arbitration: a held lock only counts while host_lock is still high, so
    // the cycle host_lock drops is already an ordinary round-robin cycle.
    always_comb begin
        lock_active = locked_q & host_lock;
        core_win    = 1'b0;
        host_win    = 1'b0;
        if (lock_active) begin
            host_win = host_req;
        end else if (core_req && host_req) begin
            if (last_owner_q == OWN_HOST) begin
                core_win = 1'b1;
            end else begin
                host_win = 1'b1;
            end
        end else begin
            core_win = core_req;
            host_win = host_req;
        end
    end

    // Grants are forced low while reset is asserted, even though the
    // request inputs may still be active.
    assign core_gnt = core_win & reset;
    assign host_gnt = host_win & reset;

    // Memory command mux: all fields read zero when nothing is granted.
    always_comb begin
        mem_en    = core_gnt | host_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (core_gnt) begin
            mem_we    = core_we;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
        end else if (host_gnt) begin
            mem_we    = host_we;
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
        end
    end

    // Read return routing: the pending read's owner sees the live memory
    // data; the other port keeps showing the last data it received.
    always_comb begin
        core_rvalid = rd_pend_q & (rd_owner_q == OWN_CORE);
        host_rvalid = rd_pend_q & (rd_owner_q == OWN_HOST);
        core_rdata  = core_rvalid ? mem_rdata : core_rdata_q;
        host_rdata  = host_rvalid ? mem_rdata : host_rdata_q;
        busy        = mem_en | rd_pend_q;
    end

    // Next-state for ownership, lock and read tracking.
    always_comb begin
        last_owner_d = last_owner_q;
        if (host_gnt) begin
            last_owner_d = OWN_HOST;
        end else if (core_gnt) begin
            last_owner_d = OWN_CORE;
        end

        // Lock is taken by a locked host grant and then persists purely on
        // host_lock, so host idle cycles inside a burst still stall the core.
        locked_d = lock_active | (host_gnt & host_lock);

        rd_pend_d  = mem_en & ~mem_we;
        rd_owner_d = rd_owner_q;
        if (rd_pend_d) begin
            rd_owner_d = host_gnt ? OWN_HOST : OWN_CORE;
        end

        core_rdata_d = core_rdata;
        host_rdata_d = host_rdata;
    end

    // State registers; async reset drops any in-flight read return.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_owner_q <= OWN_HOST;
            locked_q     <= 1'b0;
            rd_pend_q    <= 1'b0;
            rd_owner_q   <= OWN_CORE;
            core_rdata_q <= '0;
            host_rdata_q <= '0;
        end else begin
            last_owner_q <= last_owner_d;
            locked_q     <= locked_d;
            rd_pend_q    <= rd_pend_d;
            rd_owner_q   <= rd_owner_d;
            core_rdata_q <= core_rdata_d;
            host_rdata_q <= host_rdata_d;
        end
    end

endmodule
